// File: rtl/rx_drain_ctrl.sv
//-----------------------------------------------------------------------------
// rx_drain_ctrl
//
// Read-side controller for the receive core's byte FIFO. Bytes are popped
// with a single-cycle active-low read strobe and packed little-endian into
// 32-bit words (byte 0 lands in word_o[7:0]). Each completed word is offered
// to the host side over a valid/ready handshake. A partial word is flushed
// after a programmable number of baud acquisition ticks with no new byte,
// so short frames are not stranded in the packer.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-low
//   enable_i     1 = controller may start new FIFO reads and flushes
//   data_i       FIFO read data, valid the cycle after n_rd_o is low
//   n_rd_o       FIFO read strobe, active-low, one cycle per byte
//   p_empty_i    FIFO empty flag, active-high
//   AcqSig_i     baud acquisition tick, one-cycle pulse
//   timeout_i    idle flush threshold in AcqSig_i ticks, 0 = never flush
//   word_o       packed word, byte 0 in [7:0], unused lanes read 0
//   byte_cnt_o   number of valid bytes in word_o (0..4)
//   p_valid_o    word_o/byte_cnt_o/p_flush_o are valid
//   p_ready_i    consumer ready
//   p_flush_o    word is a timeout flush (byte_cnt_o < 4)
//   dbg_state_o  current FSM state (0 IDLE, 1 RD, 2 CAP, 3 OUT)
//
// Handshake: a word transfers on a rising clk edge where p_valid_o and
// p_ready_i are both 1. Once p_valid_o is raised, word_o, byte_cnt_o and
// p_flush_o stay stable and p_valid_o stays high until that transfer edge;
// p_ready_i may be asserted or withdrawn at any time without a combinational
// path to p_valid_o.
//-----------------------------------------------------------------------------
module rx_drain_ctrl #(
    parameter int TO_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable_i,
    input  logic [7:0]          data_i,
    output logic                n_rd_o,
    input  logic                p_empty_i,
    input  logic                AcqSig_i,
    input  logic [TO_WIDTH-1:0] timeout_i,
    output logic [31:0]         word_o,
    output logic [2:0]          byte_cnt_o,
    output logic                p_valid_o,
    input  logic                p_ready_i,
    output logic                p_flush_o,
    output logic [1:0]          dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t              state;
    logic [TO_WIDTH-1:0] idle_cnt;

    // Decoded IDLE conditions. A pending read always wins over a flush so
    // data already waiting in the FIFO is appended before a partial word
    // leaves.
    logic start_read;
    logic start_flush;
    logic partial;

    assign partial     = (byte_cnt_o != 3'd0);
    assign start_read  = enable_i && !p_empty_i;
    assign start_flush = partial && (timeout_i != '0) && enable_i &&
                         (idle_cnt >= timeout_i);

    assign dbg_state_o = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            n_rd_o     <= 1'b1;
            p_valid_o  <= 1'b0;
            p_flush_o  <= 1'b0;
            word_o     <= '0;
            byte_cnt_o <= '0;
            idle_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // The idle counter only runs while a partial word is
                    // held, and keeps running even when enable_i is low so
                    // a flush can follow as soon as the controller is
                    // re-enabled. It sticks at all-ones rather than wrap.
                    if (partial && AcqSig_i && (idle_cnt != '1)) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end

                    if (start_read) begin
                        state  <= RD;
                        n_rd_o <= 1'b0;
                    end else if (start_flush) begin
                        state     <= OUT;
                        p_valid_o <= 1'b1;
                        p_flush_o <= 1'b1;
                    end
                end

                RD: begin
                    // Strobe is low for exactly this one cycle; the FIFO
                    // presents the byte during CAP.
                    n_rd_o <= 1'b1;
                    state  <= CAP;
                end

                CAP: begin
                    word_o[{byte_cnt_o[1:0], 3'b000} +: 8] <= data_i;
                    byte_cnt_o <= byte_cnt_o + 3'd1;
                    idle_cnt   <= '0;
                    if (byte_cnt_o == 3'd3) begin
                        state     <= OUT;
                        p_valid_o <= 1'b1;
                        p_flush_o <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end

                OUT: begin
                    // No reads are issued here, so a stalled consumer holds
                    // bytes back in the FIFO instead of overrunning the
                    // packer.
                    if (p_ready_i) begin
                        state      <= IDLE;
                        p_valid_o  <= 1'b0;
                        p_flush_o  <= 1'b0;
                        word_o     <= '0;
                        byte_cnt_o <= '0;
                        idle_cnt   <= '0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_drain_ctrl.sv
// Directed bench for rx_drain_ctrl. A behavioural byte FIFO feeds the DUT;
// expected words are queued by the stimulus and popped by an independent
// monitor whenever the DUT completes a handshake.
module tb_rx_drain_ctrl;

    localparam int TO_WIDTH = 16;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam int WAIT_BUDGET = 500;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic                enable_i  = 1'b0;
    logic [7:0]          data_i    = 8'h00;
    logic                n_rd_o;
    logic                p_empty_i = 1'b1;
    logic                AcqSig_i  = 1'b0;
    logic [TO_WIDTH-1:0] timeout_i = '0;
    logic [31:0]         word_o;
    logic [2:0]          byte_cnt_o;
    logic                p_valid_o;
    logic                p_ready_i = 1'b1;
    logic                p_flush_o;
    logic [1:0]          dbg_state_o;

    rx_drain_ctrl #(.TO_WIDTH(TO_WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable_i    (enable_i),
        .data_i      (data_i),
        .n_rd_o      (n_rd_o),
        .p_empty_i   (p_empty_i),
        .AcqSig_i    (AcqSig_i),
        .timeout_i   (timeout_i),
        .word_o      (word_o),
        .byte_cnt_o  (byte_cnt_o),
        .p_valid_o   (p_valid_o),
        .p_ready_i   (p_ready_i),
        .p_flush_o   (p_flush_o),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    int rd_count = 0;
    logic [7:0]  fifo_q[$];
    logic [35:0] exp_q[$];   // {flush, byte_cnt[2:0], word[31:0]}

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- FIFO model ----------------
    // Pops on a low strobe and presents the byte for the following cycle.
    logic prev_nrd = 1'b1;
    always @(negedge clk) begin
        if (rst && n_rd_o == 1'b0) begin
            rd_count++;
            if (fifo_q.size() > 0) data_i = fifo_q.pop_front();
            total++;
            if (prev_nrd == 1'b0) begin
                bad++;
                $display("FAIL rd_pulse_width: got strobe low 2 cycles expected 1");
            end
        end
        prev_nrd = rst ? n_rd_o : 1'b1;
        p_empty_i = (fifo_q.size() == 0);
    end

    // ---------------- monitor / scoreboard ----------------
    logic        hold_valid = 1'b0;
    logic [35:0] hold_val;
    always @(negedge clk) begin
        if (!rst) begin
            hold_valid = 1'b0;
        end else begin
            if (hold_valid) begin
                check("stall_hold", {p_valid_o, p_flush_o, byte_cnt_o, word_o},
                      {1'b1, hold_val});
            end
            if (p_valid_o && p_ready_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %h expected none",
                             {p_flush_o, byte_cnt_o, word_o});
                end else begin
                    check("word_out", {p_flush_o, byte_cnt_o, word_o}, exp_q.pop_front());
                end
            end
            hold_valid = p_valid_o && !p_ready_i;
            hold_val   = {p_flush_o, byte_cnt_o, word_o};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        p_empty_i = 1'b0;
    endtask

    task automatic acq_pulse();
        AcqSig_i = 1'b1;
        step(1);
        AcqSig_i = 1'b0;
        step(1);
    endtask

    task automatic wait_exp_empty(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < WAIT_BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s: got %0d words pending expected 0 (timeout)", name, exp_q.size());
        end
        step(1);
    endtask

    task automatic wait_state(input logic [1:0] st, input string name);
        int n = 0;
        @(negedge clk);
        while (dbg_state_o != st && n < WAIT_BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (dbg_state_o != st) begin
            total++;
            bad++;
            $display("FAIL %s: got state %0d expected %0d (timeout)", name, dbg_state_o, st);
        end
    endtask

    task automatic wait_cnt(input logic [2:0] c, input string name);
        int n = 0;
        @(negedge clk);
        while (!(byte_cnt_o == c && dbg_state_o == ST_IDLE) && n < WAIT_BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (byte_cnt_o != c) begin
            total++;
            bad++;
            $display("FAIL %s: got byte_cnt %0d expected %0d (timeout)", name, byte_cnt_o, c);
        end
        step(1);
    endtask

    // ---------------- directed stimulus ----------------
    int rd_mark;
    initial begin
        // Reset values
        step(3);
        check("reset_outputs", {n_rd_o, p_valid_o, p_flush_o, byte_cnt_o, word_o},
              {1'b1, 1'b0, 1'b0, 3'd0, 32'h0});
        rst = 1'b1;
        step(2);
        check("reset_state", {34'h0, dbg_state_o}, {34'h0, ST_IDLE});

        // Full word with a ready consumer
        enable_i  = 1'b1;
        p_ready_i = 1'b1;
        rd_mark   = rd_count;
        exp_q.push_back({1'b0, 3'd4, 32'h44332211});
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
        wait_exp_empty("full_word");
        check("full_word_reads", 36'(rd_count - rd_mark), 36'd4);

        // Backpressure: 0x55 must stay in the FIFO while the word stalls
        p_ready_i = 1'b0;
        rd_mark   = rd_count;
        exp_q.push_back({1'b0, 3'd4, 32'h44332211});
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
        push_byte(8'h55);
        wait_state(2'd3, "bp_reach_out");
        step(10);
        check("bp_no_reads", 36'(rd_count - rd_mark), 36'd4);
        check("bp_fifo_level", 36'(fifo_q.size()), 36'd1);
        p_ready_i = 1'b1;
        wait_exp_empty("bp_accept");
        wait_cnt(3'd1, "bp_next_read");
        check("bp_next_read_count", 36'(rd_count - rd_mark), 36'd5);
        exp_q.push_back({1'b0, 3'd4, 32'h88776655});
        push_byte(8'h66); push_byte(8'h77); push_byte(8'h88);
        wait_exp_empty("bp_drain");

        // Timeout flush after the third tick
        timeout_i = 16'd3;
        push_byte(8'hAA); push_byte(8'hBB);
        wait_cnt(3'd2, "to_capture");
        acq_pulse();
        acq_pulse();
        step(3);
        check("to_no_early_flush", {35'h0, p_valid_o}, 36'h0);
        exp_q.push_back({1'b1, 3'd2, 32'h0000BBAA});
        acq_pulse();
        wait_exp_empty("to_flush");

        // Timeout disabled: 100 ticks with one byte held
        timeout_i = 16'd0;
        push_byte(8'h01);
        wait_cnt(3'd1, "dis_capture");
        for (int i = 0; i < 100; i++) acq_pulse();
        check("dis_no_flush", {32'h0, p_valid_o, byte_cnt_o}, {32'h0, 1'b0, 3'd1});

        // Race: threshold already met and FIFO goes non-empty the same cycle
        timeout_i = 16'd2;
        push_byte(8'hCC);
        wait_cnt(3'd2, "race_capture");
        check("race_append", {1'b0, byte_cnt_o, word_o}, {1'b0, 3'd2, 32'h0000CC01});
        acq_pulse();
        step(3);
        check("race_counter_restart", {35'h0, p_valid_o}, 36'h0);
        exp_q.push_back({1'b1, 3'd2, 32'h0000CC01});
        acq_pulse();
        wait_exp_empty("race_flush");

        // Enable gating
        timeout_i = 16'd0;
        enable_i  = 1'b0;
        rd_mark   = rd_count;
        push_byte(8'h5A); push_byte(8'h5B);
        step(10);
        check("gate_no_read", {35'h0, n_rd_o}, 36'h1);
        check("gate_read_count", 36'(rd_count - rd_mark), 36'd0);
        enable_i = 1'b1;
        wait_state(ST_RD, "gate_rd");
        step(1);                 // now in CAP
        enable_i = 1'b0;
        step(10);
        check("gate_cap_done", {1'b0, byte_cnt_o, word_o}, {1'b0, 3'd1, 32'h0000005A});
        check("gate_reads_stop", 36'(rd_count - rd_mark), 36'd1);
        timeout_i = 16'd1;
        acq_pulse();
        acq_pulse();
        step(2);
        check("gate_no_flush", {35'h0, p_valid_o}, 36'h0);
        timeout_i = 16'd0;
        exp_q.push_back({1'b0, 3'd4, 32'h5D5C5B5A});
        push_byte(8'h5C); push_byte(8'h5D);
        enable_i = 1'b1;
        wait_exp_empty("gate_resume");

        // Asynchronous reset mid-read with a 2-byte partial word
        push_byte(8'h10); push_byte(8'h20);
        wait_cnt(3'd2, "rst_partial");
        push_byte(8'h30);
        wait_state(ST_RD, "rst_rd");
        #2;
        rst = 1'b0;
        #1;
        check("rst_async", {n_rd_o, p_valid_o, p_flush_o, byte_cnt_o, word_o},
              {1'b1, 1'b0, 1'b0, 3'd0, 32'h0});
        enable_i = 1'b0;
        step(2);
        fifo_q.delete();
        p_empty_i = 1'b1;
        rst = 1'b1;
        step(2);
        check("rst_release_state", {31'h0, dbg_state_o, byte_cnt_o}, {31'h0, ST_IDLE, 3'd0});
        enable_i = 1'b1;
        exp_q.push_back({1'b0, 3'd4, 32'hA4A3A2A1});
        push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3); push_byte(8'hA4);
        wait_exp_empty("post_reset_word");

        step(5);
        check("queue_drained", 36'(exp_q.size()), 36'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rx_drain_ctrl.md
Name: rx_drain_ctrl

Overview:
Read-side controller for the receive core's byte FIFO. Pops bytes from the FIFO with single-cycle active-low read strobes and packs them little-endian into 32-bit words. Presents each word to the host/bus side over a valid/ready handshake. Flushes a partial word after a programmable idle time, counted in baud acquisition ticks, so short frames are not stranded.

Parameters:
TO_WIDTH, 16, width of idle-timeout counter and timeout_i.

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
enable_i  input  1  1 = controller may start new FIFO reads
data_i  input  8  FIFO read data; valid the cycle after n_rd_o low
n_rd_o  output  1  FIFO read strobe, active-low, one cycle per byte
p_empty_i  input  1  FIFO empty flag, active-high
AcqSig_i  input  1  baud acquisition tick, one-cycle pulse
timeout_i  input  TO_WIDTH  idle flush threshold in AcqSig_i ticks; 0 = flush disabled
word_o  output  32  packed word; byte 0 in [7:0]
byte_cnt_o  output  3  valid bytes in word_o, 0..4
p_valid_o  output  1  word_o/byte_cnt_o valid
p_ready_i  input  1  consumer accepts word when p_valid_o & p_ready_i
p_flush_o  output  1  high with p_valid_o when the word is a timeout flush (byte_cnt_o < 4)

Behaviour:
- Reset (rst=0, async): state IDLE; n_rd_o=1; p_valid_o=0; p_flush_o=0; word_o=0; byte_cnt_o=0; idle counter=0. A reset during a read loses the popped byte. A reset with a partial word discards that word.
- FSM states: IDLE, RD, CAP, OUT. All outputs are registered.
- IDLE:
  - Priority 1: if enable_i=1 and p_empty_i=0, go to RD.
  - Priority 2: else if byte_cnt_o>0, timeout_i!=0, enable_i=1 and idle_cnt>=timeout_i, go to OUT with p_flush_o=1.
- RD: n_rd_o=0 for exactly this one cycle. Next state is CAP unconditionally.
- CAP:
  - word_o[8*byte_cnt_o +: 8] <= data_i; byte_cnt_o <= byte_cnt_o+1; idle_cnt <= 0.
  - Next state is OUT (p_flush_o=0) if the new count is 4, else IDLE.
- OUT:
  - p_valid_o=1. word_o, byte_cnt_o and p_flush_o are held stable while p_ready_i=0.
  - On p_valid_o & p_ready_i, in that same clock edge: p_valid_o<=0, p_flush_o<=0, word_o<=0, byte_cnt_o<=0, idle_cnt<=0, next state IDLE.
  - No FIFO reads occur in OUT, so backpressure propagates to the FIFO.
- Idle counter:
  - Increments on AcqSig_i=1 only in IDLE with byte_cnt_o>0. Saturates at all-ones.
  - Held at 0 while byte_cnt_o=0. Cleared in CAP.
  - The compare uses the current timeout_i value; changing timeout_i mid-count takes effect immediately.
- Simultaneous events: in IDLE, a non-empty FIFO beats an expired timeout, so data is always appended before a flush.
- enable_i=0:
  - An in-progress RD/CAP/OUT sequence completes normally.
  - No new RD starts. No flush starts; the partial word is held and the idle counter keeps counting.
- Throughput: 3 cycles per byte (IDLE→RD→CAP) plus OUT of at least 1 cycle per word. Latency from p_empty_i falling to the first n_rd_o low is 1 cycle.
- Unused upper lanes of word_o read 0 on a flush.
- p_empty_i is sampled only in IDLE. This block is the sole FIFO reader, so the FIFO cannot go empty between IDLE and RD.

Test Plan:
- Reset values: assert rst=0 mid-RD with a partial word of 2 bytes → n_rd_o=1, p_valid_o=0, word_o=0, byte_cnt_o=0 immediately (async). After release, state is IDLE.
- Full word: FIFO holds 0x11,0x22,0x33,0x44; enable_i=1; p_ready_i=1 → exactly 4 single-cycle n_rd_o pulses. Then p_valid_o=1 with word_o=0x44332211, byte_cnt_o=4, p_flush_o=0, accepted in 1 cycle.
- Backpressure: same data, p_ready_i=0 for 10 cycles → word_o and byte_cnt_o stable and no further n_rd_o pulses while 0x55 is waiting in the FIFO. On p_ready_i=1, the word is accepted and the next read starts.
- Timeout flush: FIFO gets 0xAA,0xBB then stays empty; timeout_i=3 → after the 3rd AcqSig_i pulse, p_valid_o=1 with word_o=0x0000BBAA, byte_cnt_o=2, p_flush_o=1.
- Timeout disabled / race:
  - timeout_i=0 with 1 byte buffered for 100 ticks → no flush.
  - timeout_i=2 with the FIFO going non-empty (byte 0xCC) in the same cycle the threshold is reached → byte appended, byte_cnt_o=2, and the idle counter restarts from 0.
- Enable gating: enable_i=0 with FIFO non-empty → n_rd_o stays 1. Drop enable_i during CAP → the byte is captured, then reads stop.
